// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message feeder.
// Holds the FSM encoding and the 512-bit block geometry.
package sha256_pkg;

   localparam int         BLOCK_WORDS = 16;
   localparam int         BLOCK_BYTES = 64;
   localparam int         LEN_OFFSET  = 56;
   localparam logic [7:0] PAD_BYTE    = 8'h80;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_FILL = 3'd1,
      ST_PAD  = 3'd2,
      ST_LEN  = 3'd3,
      ST_SEND = 3'd4,
      ST_WAIT = 3'd5,
      ST_DONE = 3'd6
   } feeder_state_e;

   // True when a 0x80 marker placed at bidx still leaves the last 8 bytes free for the length.
   function automatic logic len_fits(input logic [6:0] bidx);
      return (bidx < 7'(LEN_OFFSET));
   endfunction

endpackage

// File: rtl/sha256_block_buf.sv
// 16x32 block buffer for the message feeder.
// Byte writes land big-endian within a word; the length pair always occupies words 14 and 15.
module sha256_block_buf
   import sha256_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        byte_we,
   input  logic [5:0]  byte_idx,
   input  logic [7:0]  byte_data,
   input  logic        len_we,
   input  logic [63:0] len_data,
   input  logic [3:0]  rd_idx,
   output logic [31:0] rd_data
);

   logic [31:0] mem_r [BLOCK_WORDS];

   // Block storage: reset and clear zero every word, so padding never needs explicit zero writes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < BLOCK_WORDS; i++) begin
            mem_r[i] <= 32'd0;
         end
      end else if (clr) begin
         for (int i = 0; i < BLOCK_WORDS; i++) begin
            mem_r[i] <= 32'd0;
         end
      end else begin
         if (len_we) begin
            mem_r[BLOCK_WORDS-2] <= len_data[63:32];
            mem_r[BLOCK_WORDS-1] <= len_data[31:0];
         end
         if (byte_we) begin
            case (byte_idx[1:0])
               2'd0:    mem_r[byte_idx[5:2]][31:24] <= byte_data;
               2'd1:    mem_r[byte_idx[5:2]][23:16] <= byte_data;
               2'd2:    mem_r[byte_idx[5:2]][15:8]  <= byte_data;
               2'd3:    mem_r[byte_idx[5:2]][7:0]   <= byte_data;
               default: mem_r[byte_idx[5:2]][31:24] <= byte_data;
            endcase
         end
      end
   end

   assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/sha256_msg_feeder.sv
// Byte-stream front end for the SHA-256 core: packs, pads and appends the bit length,
// then streams each 512-bit block as a 16-word burst paced by the core's idle flag.
module sha256_msg_feeder
   import sha256_pkg::*;
#(
   parameter int LEN_W = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  msg_byte_i,
   input  logic        msg_valid_i,
   input  logic        msg_last_i,
   output logic        msg_ready_o,
   input  logic        hash_vaild_i,
   output logic        dat_vaild_o,
   output logic [31:0] dat_o,
   output logic        busy_o,
   output logic        msg_done_o
);

   localparam int CNT_W = LEN_W - 3;

   feeder_state_e    state_r, state_s;
   logic [6:0]       bidx_r, bidx_s;
   logic [3:0]       widx_r, widx_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic             need_len_r, need_len_s;
   logic             final_r, final_s;
   logic             boundary_r, boundary_s;
   logic             hash_low_r, hash_low_s;

   logic             msg_ready_r, dat_vaild_r, busy_r, msg_done_r;
   logic [31:0]      dat_r;

   logic             accept_s;
   logic             buf_clr_s, buf_bwe_s, buf_lwe_s;
   logic [5:0]       buf_bidx_s;
   logic [7:0]       buf_bdata_s;
   logic [LEN_W-1:0] bitlen_s;
   logic [63:0]      len64_s;
   logic [31:0]      rd_data_s;

   assign accept_s = msg_valid_i & msg_ready_r;
   assign bitlen_s = {cnt_r, 3'b000};
   assign len64_s  = 64'(bitlen_s);

   sha256_block_buf u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (buf_clr_s),
      .byte_we   (buf_bwe_s),
      .byte_idx  (buf_bidx_s),
      .byte_data (buf_bdata_s),
      .len_we    (buf_lwe_s),
      .len_data  (len64_s),
      .rd_idx    (widx_s),
      .rd_data   (rd_data_s)
   );

   // Next-state, counter and buffer-control decode.
   always_comb begin
      state_s     = state_r;
      bidx_s      = bidx_r;
      widx_s      = widx_r;
      cnt_s       = cnt_r;
      need_len_s  = need_len_r;
      final_s     = final_r;
      boundary_s  = boundary_r;
      hash_low_s  = hash_low_r;
      buf_clr_s   = 1'b0;
      buf_bwe_s   = 1'b0;
      buf_lwe_s   = 1'b0;
      buf_bidx_s  = bidx_r[5:0];
      buf_bdata_s = msg_byte_i;
      case (state_r)
         ST_IDLE: begin
            buf_bidx_s = 6'd0;
            if (accept_s) begin
               buf_bwe_s  = 1'b1;
               bidx_s     = 7'd1;
               cnt_s      = CNT_W'(1);
               need_len_s = 1'b0;
               final_s    = 1'b0;
               boundary_s = 1'b0;
               state_s    = msg_last_i ? ST_PAD : ST_FILL;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FILL: begin
            if (accept_s) begin
               buf_bwe_s = 1'b1;
               bidx_s    = bidx_r + 7'd1;
               cnt_s     = cnt_r + CNT_W'(1);
               if (bidx_r == 7'(BLOCK_BYTES - 1)) begin
                  boundary_s = msg_last_i;
                  widx_s     = 4'd0;
                  state_s    = ST_SEND;
               end else if (msg_last_i) begin
                  state_s = ST_PAD;
               end else begin
                  state_s = ST_FILL;
               end
            end else begin
               state_s = ST_FILL;
            end
         end
         ST_PAD: begin
            buf_bwe_s   = 1'b1;
            buf_bdata_s = PAD_BYTE;
            if (len_fits(bidx_r)) begin
               state_s = ST_LEN;
            end else begin
               need_len_s = 1'b1;
               widx_s     = 4'd0;
               state_s    = ST_SEND;
            end
         end
         ST_LEN: begin
            buf_lwe_s = 1'b1;
            final_s   = 1'b1;
            widx_s    = 4'd0;
            state_s   = ST_SEND;
         end
         ST_SEND: begin
            if (widx_r == 4'(BLOCK_WORDS - 1)) begin
               buf_clr_s  = 1'b1;
               bidx_s     = 7'd0;
               widx_s     = 4'd0;
               hash_low_s = 1'b0;
               state_s    = ST_WAIT;
            end else begin
               widx_s  = widx_r + 4'd1;
               state_s = ST_SEND;
            end
         end
         ST_WAIT: begin
            // Only a rising idle flag after a seen low counts as the core finishing this block.
            if (hash_low_r && hash_vaild_i) begin
               hash_low_s = 1'b0;
               if (final_r) begin
                  final_s = 1'b0;
                  state_s = ST_DONE;
               end else if (need_len_r) begin
                  need_len_s = 1'b0;
                  state_s    = ST_LEN;
               end else if (boundary_r) begin
                  boundary_s = 1'b0;
                  state_s    = ST_PAD;
               end else begin
                  state_s = ST_FILL;
               end
            end else begin
               hash_low_s = hash_low_r | ~hash_vaild_i;
               state_s    = ST_WAIT;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, counters and outputs registered from the next state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         bidx_r      <= 7'd0;
         widx_r      <= 4'd0;
         cnt_r       <= '0;
         need_len_r  <= 1'b0;
         final_r     <= 1'b0;
         boundary_r  <= 1'b0;
         hash_low_r  <= 1'b0;
         msg_ready_r <= 1'b0;
         dat_vaild_r <= 1'b0;
         dat_r       <= 32'd0;
         busy_r      <= 1'b0;
         msg_done_r  <= 1'b0;
      end else begin
         state_r     <= state_s;
         bidx_r      <= bidx_s;
         widx_r      <= widx_s;
         cnt_r       <= cnt_s;
         need_len_r  <= need_len_s;
         final_r     <= final_s;
         boundary_r  <= boundary_s;
         hash_low_r  <= hash_low_s;
         msg_ready_r <= (state_s == ST_IDLE) || (state_s == ST_FILL);
         dat_vaild_r <= (state_s == ST_SEND);
         dat_r       <= (state_s == ST_SEND) ? rd_data_s : 32'd0;
         busy_r      <= (state_s != ST_IDLE);
         msg_done_r  <= (state_s == ST_DONE);
      end
   end

   assign msg_ready_o = msg_ready_r;
   assign dat_vaild_o = dat_vaild_r;
   assign dat_o       = dat_r;
   assign busy_o      = busy_r;
   assign msg_done_o  = msg_done_r;

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Randomized bench for sha256_msg_feeder: a padding model builds the expected blocks,
// and a core model paces blocks through hash_vaild_i while recording what the DUT emits.
module tb_sha256_msg_feeder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  msg_byte_i;
   logic        msg_valid_i;
   logic        msg_last_i;
   logic        msg_ready_o;
   logic        hash_vaild_i;
   logic        dat_vaild_o;
   logic [31:0] dat_o;
   logic        busy_o;
   logic        msg_done_o;

   sha256_msg_feeder #(.LEN_W(64)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .msg_byte_i   (msg_byte_i),
      .msg_valid_i  (msg_valid_i),
      .msg_last_i   (msg_last_i),
      .msg_ready_o  (msg_ready_o),
      .hash_vaild_i (hash_vaild_i),
      .dat_vaild_o  (dat_vaild_o),
      .dat_o        (dat_o),
      .busy_o       (busy_o),
      .msg_done_o   (msg_done_o)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Written only by the core model.
   int          cyc = 0;
   logic [31:0] obs_words[$];
   int          burst_lens[$];
   int          burst_gap[$];
   int          done_total = 0;
   int          ready_viol = 0;
   int          early_burst = 0;
   int          done_in_wait = 0;
   int          busy_viol = 0;

   // Written only by the main sequence.
   logic        mon_en = 1'b0;
   int          stale_n = 0;
   int          low_n = 2;
   logic [7:0]  msg_q[$];
   logic [31:0] exp_words[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Core model: idle level stays high through a burst (stale), then low, then high again.
   initial begin : core_model
      int   cur_len;
      int   rel_cnt;
      int   last_acc;
      logic in_burst;
      logic window;
      logic releasing;
      cur_len = 0; rel_cnt = 0; last_acc = 0;
      in_burst = 1'b0; window = 1'b0; releasing = 1'b0;
      hash_vaild_i = 1'b1;
      forever begin
         @(negedge clk);
         cyc++;
         if (!mon_en) begin
            in_burst = 1'b0; window = 1'b0; releasing = 1'b0;
            hash_vaild_i = 1'b1;
         end else begin
            if (msg_valid_i && msg_ready_o && msg_last_i) last_acc = cyc;
            if (window && msg_ready_o) ready_viol++;
            if (msg_done_o) begin
               done_total++;
               if (window) done_in_wait++;
               if (!busy_o) busy_viol++;
            end
            if (dat_vaild_o) begin
               if (!in_burst) begin
                  if (window) early_burst++;
                  in_burst = 1'b1;
                  cur_len  = 0;
                  window   = 1'b1;
                  burst_gap.push_back(cyc - last_acc);
               end
               obs_words.push_back(dat_o);
               cur_len++;
            end else if (in_burst) begin
               in_burst  = 1'b0;
               burst_lens.push_back(cur_len);
               releasing = 1'b1;
               rel_cnt   = stale_n + low_n;
            end
            if (releasing) begin
               if (rel_cnt == 0) begin
                  hash_vaild_i = 1'b1;
                  releasing    = 1'b0;
                  window       = 1'b0;
               end else begin
                  hash_vaild_i = (rel_cnt > low_n);
                  rel_cnt--;
               end
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic last);
      int guard;
      @(posedge clk); #1;
      if ($urandom_range(0, 3) == 0) begin
         msg_valid_i = 1'b0;
         msg_last_i  = 1'($urandom_range(0, 1));
         msg_byte_i  = 8'($urandom);
         repeat ($urandom_range(1, 3)) begin
            @(posedge clk); #1;
         end
      end
      msg_byte_i  = b;
      msg_last_i  = last;
      msg_valid_i = 1'b1;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!msg_ready_o && guard < 3000);
      if (guard >= 3000) check_eq("ready_timeout", 64'(msg_ready_o), 64'd1);
   endtask

   task automatic run_msg(input int len, input int kind);
      logic [7:0]  pad[$];
      logic [63:0] bits;
      int w0, b0, d0, rv0, eb0, dw0, bv0, guard, nblk;
      msg_q.delete();
      exp_words.delete();
      for (int i = 0; i < len; i++) begin
         case (kind)
            0:       msg_q.push_back(8'h61 + 8'(i));
            1:       msg_q.push_back(8'h41);
            default: msg_q.push_back(8'($urandom));
         endcase
      end
      pad = msg_q;
      pad.push_back(8'h80);
      while (pad.size() % 64 != 56) pad.push_back(8'h00);
      bits = 64'(len) * 64'd8;
      for (int i = 7; i >= 0; i--) pad.push_back(bits[8*i +: 8]);
      for (int i = 0; i < pad.size(); i += 4)
         exp_words.push_back({pad[i], pad[i+1], pad[i+2], pad[i+3]});
      nblk = pad.size() / 64;

      w0 = obs_words.size(); b0 = burst_lens.size(); d0 = done_total;
      rv0 = ready_viol; eb0 = early_burst; dw0 = done_in_wait; bv0 = busy_viol;

      for (int i = 0; i < len; i++) send_byte(msg_q[i], (i == len - 1));
      @(posedge clk); #1;
      msg_valid_i = 1'b0;
      msg_last_i  = 1'b0;

      guard = 0;
      while (done_total == d0 && guard < 8000) begin
         @(negedge clk);
         guard++;
      end
      check_eq("done_seen", 64'(done_total != d0), 64'd1);
      repeat (3) @(negedge clk);
      check_eq("busy_after_done", 64'(busy_o), 64'd0);
      check_eq("ready_after_done", 64'(msg_ready_o), 64'd1);
      check_eq("done_pulses", 64'(done_total - d0), 64'd1);
      check_eq("burst_count", 64'(burst_lens.size() - b0), 64'(nblk));
      for (int i = b0; i < burst_lens.size(); i++)
         check_eq("burst_len", 64'(burst_lens[i]), 64'd16);
      check_eq("word_count", 64'(obs_words.size() - w0), 64'(exp_words.size()));
      for (int i = 0; i < exp_words.size() && (w0 + i) < obs_words.size(); i++)
         check_eq($sformatf("len%0d_word%0d", len, i), 64'(obs_words[w0+i]), 64'(exp_words[i]));
      if (len % 64 != 0 && len % 64 <= 55)
         check_eq("last_to_burst", 64'(burst_gap[burst_gap.size()-1]), 64'd3);
      check_eq("ready_in_wait", 64'(ready_viol - rv0), 64'd0);
      check_eq("burst_before_idle", 64'(early_burst - eb0), 64'd0);
      check_eq("done_before_idle", 64'(done_in_wait - dw0), 64'd0);
      check_eq("busy_at_done", 64'(busy_viol - bv0), 64'd0);
   endtask

   initial begin
      int guard;
      rst_n       = 1'b0;
      msg_valid_i = 1'b0;
      msg_last_i  = 1'b0;
      msg_byte_i  = 8'h00;
      repeat (3) @(negedge clk);
      check_eq("rst_ready", 64'(msg_ready_o), 64'd0);
      check_eq("rst_dat_vaild", 64'(dat_vaild_o), 64'd0);
      check_eq("rst_dat", 64'(dat_o), 64'd0);
      check_eq("rst_busy", 64'(busy_o), 64'd0);
      check_eq("rst_done", 64'(msg_done_o), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("idle_ready", 64'(msg_ready_o), 64'd1);
      mon_en = 1'b1;

      stale_n = 0; low_n = 2;   run_msg(3, 0);
      run_msg(55, 1);
      stale_n = 3;              run_msg(56, 1);
      stale_n = 0; low_n = 100; run_msg(64, 1);
      low_n = 40;               run_msg(119, 2);
      low_n = 3;
      run_msg(63, 2);
      run_msg(120, 2);
      run_msg(128, 2);
      run_msg(1, 2);
      for (int k = 0; k < 8; k++) begin
         stale_n = $urandom_range(0, 3);
         low_n   = $urandom_range(1, 8);
         run_msg($urandom_range(1, 200), 2);
      end

      // Abort a burst with reset, then confirm a clean restart.
      mon_en = 1'b0;
      @(negedge clk);
      send_byte(8'h61, 1'b0);
      send_byte(8'h62, 1'b0);
      send_byte(8'h63, 1'b1);
      @(posedge clk); #1;
      msg_valid_i = 1'b0;
      msg_last_i  = 1'b0;
      guard = 0;
      while (!dat_vaild_o && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check_eq("abort_burst_start", 64'(dat_vaild_o), 64'd1);
      repeat (7) @(negedge clk);
      check_eq("abort_mid_burst", 64'(dat_vaild_o), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("abort_dat_vaild", 64'(dat_vaild_o), 64'd0);
      check_eq("abort_busy", 64'(busy_o), 64'd0);
      check_eq("abort_ready", 64'(msg_ready_o), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
      stale_n = 0; low_n = 2;
      run_msg(3, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sha256_msg_feeder.md
Name: sha256_msg_feeder

Overview:
- Front end for the SHA-256 core. Accepts a message as a byte stream and packs it big-endian into 32-bit words.
- Applies standard SHA-256 padding: a 0x80 byte, zero fill, and the 64-bit message bit length.
- Emits each 512-bit block as a burst of 16 consecutive valid words on the core's load interface (dat_vaild/dat_lsb).
- Paces blocks using the core's hash_vaild (high only while the core is idle).

Parameters:
- LEN_W, 64, width of the bit-length field appended to the message. Must be ≤64; the field is zero-extended to 64 bits in words 14/15.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- msg_byte_i  input  8  message byte
- msg_valid_i  input  1  msg_byte_i valid
- msg_last_i  input  1  qualifies the final byte of the message
- msg_ready_o  output  1  byte accepted when msg_valid_i & msg_ready_o
- hash_vaild_i  input  1  core idle / hash stable (core hash_vaild_o)
- dat_vaild_o  output  1  to core dat_vaild_i
- dat_o  output  32  to core dat_lsb_i
- busy_o  output  1  high from first accepted byte until msg_done_o
- msg_done_o  output  1  one-cycle pulse: final block hashed, core hash outputs valid

Behaviour:
- Reset (rst_n low at a clk edge, any state): state IDLE; byte index, word index and byte counter cleared; block buffer cleared; all outputs 0.
- Storage:
  - Block buffer: 16x32 registers.
  - Byte index bidx: 7 bits, 0..64.
  - Byte counter: LEN_W-3 bits; wraps modulo 2^(LEN_W-3).
  - Byte b of a block is stored in word b/4, bits [31-8*(b%4) -: 8].
- States: IDLE, FILL, PAD, LEN, SEND, WAIT, DONE.
- IDLE:
  - msg_ready_o=1.
  - An accepted byte is written at bidx 0, bidx becomes 1, busy_o rises next cycle, and the state moves to FILL, or to PAD if msg_last_i.
- FILL:
  - msg_ready_o=1 while bidx<64.
  - Each accepted byte is written at bidx; bidx and the byte counter increment.
  - Accepted byte with msg_last_i → PAD.
  - If bidx reaches 64 → SEND, with a flag remembering whether last was seen.
- PAD (1 cycle):
  - Write 0x80 at bidx.
  - If bidx ≤ 55 → LEN.
  - Else → SEND with flag need_len_block=1. The rest of this block stays zero.
  - If the message ended exactly at a 64-byte boundary, PAD is entered after WAIT with bidx=0.
- LEN (1 cycle): word14 = bitlen[63:32], word15 = bitlen[31:0], where bitlen = byte count × 8. Then → SEND with final_block=1.
- SEND (16 cycles):
  - dat_vaild_o=1 and dat_o=buffer[widx], for widx 0..15 on consecutive cycles with no gaps.
  - On the widx=15 cycle: buffer cleared to zero, bidx=0, → WAIT.
- WAIT:
  - dat_vaild_o=0, msg_ready_o=0.
  - Wait for hash_vaild_i to be low for at least one cycle, then high. This prevents a stale idle level being taken as completion.
  - Then:
    - final_block → DONE.
    - need_len_block → LEN.
    - Message ended exactly on a block boundary → PAD.
    - Otherwise → FILL.
- DONE (1 cycle): msg_done_o=1, busy_o=0 next cycle → IDLE.
- No bytes are accepted in PAD, LEN, SEND, WAIT or DONE.
- msg_last_i is ignored unless the byte is accepted.
- Zero-length messages are not supported; every message contains ≥1 byte.
- dat_vaild_o is low for ≥1 cycle between blocks, which guarantees the core's counter clears in IDLE.
- Latency, from accepting the last byte to the first dat_vaild_o:
  - 3 cycles (PAD, LEN, first SEND) when the final block has room for the length.
  - Otherwise gated by the core.

Decomposition:
- Package sha256_pkg:
  - State encoding.
  - BLOCK_WORDS=16, BLOCK_BYTES=64, LEN_OFFSET=56, PAD_BYTE=8'h80.
- One sub-module: sha256_block_buf, the 16x32 buffer with byte-write port, two-word length write, word read port and synchronous clear.
- The FSM and counters stay in sha256_msg_feeder.

Test Plan:
- "abc" (0x61,0x62,0x63+last), hash_vaild_i pulsed low/high → one 16-word burst: 0x61626380, 13×0x00000000, 0x00000000, 0x00000018; one msg_done_o pulse.
- 55 bytes of 0x41 → single block; word13 = 0x41414180, word15 = 0x000001B8.
- 56 bytes of 0x41 → block1: word14 = 0x80000000, word15 = 0; no second burst until hash_vaild_i low→high; block2: zeros, word15 = 0x000001C0.
- 64 bytes → block1 holds data only; block2 = 0x80000000, zeros, word15 = 0x00000200; msg_ready_o low from byte 64 until done.
- Backpressure: hold hash_vaild_i low 100 cycles during WAIT → dat_vaild_o stays 0, no byte accepted, msg_done_o absent until the rise.
- Reset asserted mid-SEND (widx=7) → next cycle dat_vaild_o=0 and busy_o=0; a subsequent "abc" yields the exact block from the first scenario.
